// File: rtl/mem_boot_loader.sv
// Byte-stream boot loader: parses a framed image from the UART, writes it word by word
// into the instruction/data memory backdoor and releases the CPU only on a good checksum.
module mem_boot_loader #(
    parameter int ADDRWIDTH = 12,
    parameter int TOWIDTH   = 20,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                 i_hclk,
    input  logic                 i_hresetn,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_start,
    output logic                 o_wr,
    output logic [ADDRWIDTH-1:0] o_wraddr,
    output logic [31:0]          o_wrdata,
    output logic                 o_cpu_hold,
    output logic                 o_done,
    output logic                 o_error,
    output logic [1:0]           o_errcode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]         MAGIC   = 8'hA5;
    localparam logic [16:0]        MAX_LEN = 17'd1 << ADDRWIDTH;
    localparam logic [TOWIDTH-1:0] TO_MAX  = TOWIDTH'(TIMEOUT);

    state_t               r_state;
    logic [15:0]          r_len;
    logic [16:0]          r_wordCnt;
    logic [1:0]           r_byteCnt;
    logic [23:0]          r_shift;
    logic [7:0]           r_sum;
    logic [TOWIDTH-1:0]   r_toCnt;
    logic                 r_wr;
    logic [ADDRWIDTH-1:0] r_wraddr;
    logic [31:0]          r_wrdata;
    logic                 r_cpuHold;
    logic                 r_done;
    logic                 r_error;
    logic [1:0]           r_errcode;

    logic [15:0] w_len;
    logic        w_active;
    logic        w_timeout;

    assign w_len     = {i_rx_data, r_len[7:0]};
    assign w_active  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CHECK);
    assign w_timeout = w_active && !i_rx_valid && (r_toCnt == TO_MAX);

    // Frame parser; the write register is separate from the shift register so a
    // back-to-back next word cannot disturb the data being written.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_wordCnt <= '0;
            r_byteCnt <= '0;
            r_shift   <= '0;
            r_sum     <= '0;
            r_toCnt   <= '0;
            r_wr      <= 1'b0;
            r_wraddr  <= '0;
            r_wrdata  <= '0;
            r_cpuHold <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_errcode <= 2'd0;
        end else begin
            r_wr <= 1'b0;
            if (r_wr) begin
                r_wraddr <= r_wraddr + 1'b1;
            end

            if (!w_active || i_rx_valid) begin
                r_toCnt <= '0;
            end else if (!w_timeout) begin
                r_toCnt <= r_toCnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid && (i_rx_data == MAGIC)) begin
                        r_state   <= S_LEN0;
                        r_sum     <= '0;
                        r_byteCnt <= '0;
                        r_wordCnt <= '0;
                        r_wraddr  <= '0;
                    end
                end
                S_LEN0: begin
                    if (i_rx_valid) begin
                        r_len[7:0] <= i_rx_data;
                        r_state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (i_rx_valid) begin
                        r_len[15:8] <= i_rx_data;
                        if (w_len == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if ({1'b0, w_len} > MAX_LEN) begin
                            r_state   <= S_ERR;
                            r_error   <= 1'b1;
                            r_errcode <= 2'd2;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (i_rx_valid) begin
                        r_sum     <= r_sum + i_rx_data;
                        r_byteCnt <= r_byteCnt + 2'd1;
                        if (r_byteCnt == 2'd3) begin
                            r_wr      <= 1'b1;
                            r_wrdata  <= {i_rx_data, r_shift};
                            r_wordCnt <= r_wordCnt + 17'd1;
                            if ((r_wordCnt + 17'd1) == {1'b0, r_len}) begin
                                r_state <= S_CHECK;
                            end
                        end else begin
                            r_shift <= {i_rx_data, r_shift[23:8]};
                        end
                    end
                end
                S_CHECK: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == r_sum) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpuHold <= 1'b0;
                        end else begin
                            r_state   <= S_ERR;
                            r_error   <= 1'b1;
                            r_errcode <= 2'd1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (i_start) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_errcode <= 2'd0;
                        r_cpuHold <= 1'b1;
                        r_wraddr  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_timeout) begin
                r_state   <= S_ERR;
                r_error   <= 1'b1;
                r_errcode <= 2'd3;
            end
        end
    end

    assign o_wr       = r_wr;
    assign o_wraddr   = r_wraddr;
    assign o_wrdata   = r_wrdata;
    assign o_cpu_hold = r_cpuHold;
    assign o_done     = r_done;
    assign o_error    = r_error;
    assign o_errcode  = r_errcode;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed self-checking bench for mem_boot_loader: good/bad frames, length limit,
// timeout, noise with an empty frame, and reset in the middle of a frame.
module tb_mem_boot_loader;

    localparam int ADDRWIDTH = 12;
    localparam int TOWIDTH   = 20;
    localparam int TIMEOUT   = 40;

    logic                 clk;
    logic                 rst_n;
    logic                 rxValid;
    logic [7:0]           rxData;
    logic                 startReq;
    logic                 wr;
    logic [ADDRWIDTH-1:0] wrAddr;
    logic [31:0]          wrData;
    logic                 cpuHold;
    logic                 done;
    logic                 errFlag;
    logic [1:0]           errCode;

    int checkCount = 0;
    int passCount  = 0;
    int wrCount    = 0;
    int wrBase     = 0;
    logic [31:0] wrAddrLog [16];
    logic [31:0] wrDataLog [16];

    mem_boot_loader #(
        .ADDRWIDTH(ADDRWIDTH),
        .TOWIDTH  (TOWIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_hclk    (clk),
        .i_hresetn (rst_n),
        .i_rx_valid(rxValid),
        .i_rx_data (rxData),
        .i_start   (startReq),
        .o_wr      (wr),
        .o_wraddr  (wrAddr),
        .o_wrdata  (wrData),
        .o_cpu_hold(cpuHold),
        .o_done    (done),
        .o_error   (errFlag),
        .o_errcode (errCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write strobe seen away from the active edge.
    always @(negedge clk) begin
        if (wr) begin
            wrAddrLog[wrCount % 16] = 32'(wrAddr);
            wrDataLog[wrCount % 16] = wrData;
            wrCount = wrCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed === expected) begin
            passCount = passCount + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; presents one byte for the next rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic sendBytes(input logic [7:0] bytes [], input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(bytes[i]);
        end
    endtask

    task automatic pulseStart();
        startReq = 1'b1;
        @(negedge clk);
        startReq = 1'b0;
    endtask

    task automatic waitError(input int budget);
        for (int i = 0; i < budget && !errFlag; i++) begin
            @(negedge clk);
        end
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] data);
        checkOutput({tag, "Addr"}, wrAddrLog[(wrBase + idx) % 16], addr);
        checkOutput({tag, "Data"}, wrDataLog[(wrBase + idx) % 16], data);
    endtask

    logic [7:0] frame [];

    initial begin
        rst_n    = 1'b0;
        rxValid  = 1'b0;
        rxData   = 8'h00;
        startReq = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstWr", 32'(wr), 32'd0);
        checkOutput("rstAddr", 32'(wrAddr), 32'd0);
        checkOutput("rstData", wrData, 32'd0);
        checkOutput("rstHold", 32'(cpuHold), 32'd1);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(errFlag), 32'd0);
        checkOutput("rstCode", 32'(errCode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good load; payload byte sum is 0x44C, so the checksum byte is 0x4C.
        wrBase = wrCount;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        sendBytes(frame, 12);
        checkOutput("goodDone", 32'(done), 32'd1);
        checkOutput("goodHold", 32'(cpuHold), 32'd0);
        checkOutput("goodErr", 32'(errFlag), 32'd0);
        checkOutput("goodWrCnt", 32'(wrCount - wrBase), 32'd2);
        checkWrite("goodW0", 0, 32'd0, 32'h12345678);
        checkWrite("goodW1", 1, 32'd1, 32'hDEADBEEF);
        pulseStart();
        checkOutput("goodRearmDone", 32'(done), 32'd0);
        checkOutput("goodRearmHold", 32'(cpuHold), 32'd1);
        checkOutput("goodRearmAddr", 32'(wrAddr), 32'd0);

        // Same frame with a wrong checksum byte.
        wrBase = wrCount;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D};
        sendBytes(frame, 12);
        checkOutput("badErr", 32'(errFlag), 32'd1);
        checkOutput("badCode", 32'(errCode), 32'd1);
        checkOutput("badHold", 32'(cpuHold), 32'd1);
        checkOutput("badDone", 32'(done), 32'd0);
        checkOutput("badWrCnt", 32'(wrCount - wrBase), 32'd2);
        checkWrite("badW0", 0, 32'd0, 32'h12345678);
        checkWrite("badW1", 1, 32'd1, 32'hDEADBEEF);
        pulseStart();
        checkOutput("badRearmErr", 32'(errFlag), 32'd0);
        checkOutput("badRearmCode", 32'(errCode), 32'd0);
        checkOutput("badRearmDone", 32'(done), 32'd0);

        // LEN=4096 is accepted; the stalled frame then times out in DATA.
        wrBase = wrCount;
        frame = '{8'hA5, 8'h00, 8'h10};
        sendBytes(frame, 3);
        checkOutput("len4096Err", 32'(errFlag), 32'd0);
        waitError(TIMEOUT + 10);
        checkOutput("len4096Tmo", 32'(errCode), 32'd3);
        pulseStart();

        // LEN=4097 is rejected right after the third byte.
        frame = '{8'hA5, 8'h01, 8'h10};
        sendBytes(frame, 3);
        checkOutput("len4097Err", 32'(errFlag), 32'd1);
        checkOutput("len4097Code", 32'(errCode), 32'd2);
        checkOutput("lenWrCnt", 32'(wrCount - wrBase), 32'd0);
        pulseStart();

        // Timeout after a partial word.
        wrBase = wrCount;
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11};
        sendBytes(frame, 4);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("tmoEarly", 32'(errFlag), 32'd0);
        waitError(10);
        checkOutput("tmoErr", 32'(errFlag), 32'd1);
        checkOutput("tmoCode", 32'(errCode), 32'd3);
        checkOutput("tmoHold", 32'(cpuHold), 32'd1);
        checkOutput("tmoWrCnt", 32'(wrCount - wrBase), 32'd0);
        pulseStart();

        // Noise in IDLE, then an empty frame with checksum 0.
        wrBase = wrCount;
        frame = '{8'h00, 8'hFF, 8'h5A};
        sendBytes(frame, 3);
        checkOutput("noiseErr", 32'(errFlag), 32'd0);
        checkOutput("noiseDone", 32'(done), 32'd0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        sendBytes(frame, 4);
        checkOutput("emptyDone", 32'(done), 32'd1);
        checkOutput("emptyErr", 32'(errFlag), 32'd0);
        checkOutput("emptyWrCnt", 32'(wrCount - wrBase), 32'd0);
        pulseStart();

        // Reset in DATA after one full word and two bytes of the next one.
        wrBase = wrCount;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendBytes(frame, 9);
        checkOutput("midAddr", 32'(wrAddr), 32'd1);
        checkOutput("midData", wrData, 32'h44332211);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncWr", 32'(wr), 32'd0);
        checkOutput("asyncAddr", 32'(wrAddr), 32'd0);
        checkOutput("asyncData", wrData, 32'd0);
        checkOutput("asyncHold", 32'(cpuHold), 32'd1);
        checkOutput("asyncDone", 32'(done), 32'd0);
        checkOutput("asyncErr", 32'(errFlag), 32'd0);
        checkOutput("asyncCode", 32'(errCode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wrBase = wrCount;
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        sendBytes(frame, 12);
        checkOutput("reloadDone", 32'(done), 32'd1);
        checkOutput("reloadWrCnt", 32'(wrCount - wrBase), 32'd2);
        checkWrite("reloadW0", 0, 32'd0, 32'h12345678);
        checkWrite("reloadW1", 1, 32'd1, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
